// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay: colours, letter codes,
// glyph geometry and the reveal state encoding.
package text_overlay_pkg;

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;

  localparam logic [4:0]  CHAR_A     = 5'd0;
  localparam logic [4:0]  CHAR_BLANK = 5'd31;
  localparam logic [4:0]  NUM_GLYPHS = 5'd26;

  localparam int          GLYPH_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TYPE = 2'd1,
    ST_DONE = 2'd2
  } reveal_state_e;

  // Codes at or above NUM_GLYPHS render as background.
  function automatic logic is_visible_code(input logic [4:0] code);
    return code < NUM_GLYPHS;
  endfunction

endpackage

// File: rtl/text_reveal_fsm.sv
// Typewriter reveal: counts frames via vsync rising edges and advances the
// number of visible characters, pulsing done when the whole line is shown.
module text_reveal_fsm
  import text_overlay_pkg::*;
#(
  parameter int MAX_CHARS       = 16,
  parameter int FRAMES_PER_CHAR = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       clear,
  output logic [5:0] reveal_cnt,
  output logic       done
);

  localparam int            FW          = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_CHAR - 1);
  localparam logic [5:0]    REVEAL_FULL = 6'(MAX_CHARS);

  reveal_state_e state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [5:0]    reveal_cnt_q, reveal_cnt_d;
  logic          done_q, done_d;
  logic          vsync_q, vsync_d;
  logic          frame_tick;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    reveal_cnt_d = reveal_cnt_q;
    done_d       = 1'b0;
    vsync_d      = vsync_in;
    frame_tick   = vsync_in & ~vsync_q;

    // clear beats start; start swallows any tick arriving with it
    if (clear) begin
      state_d      = ST_IDLE;
      frame_cnt_d  = FW'(0);
      reveal_cnt_d = 6'd0;
    end else if (start) begin
      state_d      = ST_TYPE;
      frame_cnt_d  = FW'(0);
      reveal_cnt_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          frame_cnt_d  = FW'(0);
          reveal_cnt_d = 6'd0;
        end
        ST_TYPE: begin
          if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_d  = FW'(0);
              reveal_cnt_d = reveal_cnt_q + 6'd1;
              if (reveal_cnt_d == REVEAL_FULL) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_TYPE;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FW'(1);
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        ST_DONE: begin
          reveal_cnt_d = REVEAL_FULL;
        end
        default: begin
          state_d      = ST_IDLE;
          frame_cnt_d  = FW'(0);
          reveal_cnt_d = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= FW'(0);
      reveal_cnt_q <= 6'd0;
      done_q       <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      reveal_cnt_q <= reveal_cnt_d;
      done_q       <= done_d;
      vsync_q      <= vsync_d;
    end
  end

  assign reveal_cnt = reveal_cnt_q;
  assign done       = done_q;

endmodule

// File: rtl/text_overlay.sv
// One-line text box overlay: three-stage pixel pipeline that addresses the
// letter glyph ROM and mixes its bit into the RGB565 stream.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int          TEXT_X0         = 192,
  parameter int          TEXT_Y0         = 232,
  parameter int          MAX_CHARS       = 16,
  parameter int          FRAMES_PER_CHAR = 8,
  parameter logic [15:0] TEXT_COLOR      = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [15:0] rgb_in,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [4:0]  wr_char,
  input  logic        start,
  input  logic        clear,
  output logic [4:0]  letter_i,
  output logic [3:0]  letter_x,
  output logic [3:0]  letter_y,
  input  logic        letter_o,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [15:0] rgb_out,
  output logic        done
);

  localparam int          AW    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [5:0]  SLOTS = 6'(MAX_CHARS);
  localparam logic [10:0] X_LO  = 11'(TEXT_X0);
  localparam logic [10:0] X_HI  = 11'(TEXT_X0 + GLYPH_W * MAX_CHARS);
  localparam logic [10:0] Y_LO  = 11'(TEXT_Y0);
  localparam logic [10:0] Y_HI  = 11'(TEXT_Y0 + GLYPH_W);

  logic [4:0]  buf_q [MAX_CHARS];
  logic [4:0]  buf_d [MAX_CHARS];

  logic        in_box_q, in_box_d;
  logic [4:0]  col_q, col_d;
  logic [3:0]  lx_q, lx_d, ly_q, ly_d;
  logic [15:0] rgb_d1_q, rgb_d1_d;

  logic [4:0]  letter_i_q, letter_i_d;
  logic [3:0]  letter_x_q, letter_x_d, letter_y_q, letter_y_d;
  logic        show_q, show_d;
  logic [15:0] rgb_d2_q, rgb_d2_d;

  logic [15:0] rgb_out_q, rgb_out_d;
  logic [2:0]  hs_q, hs_d, vs_q, vs_d;

  logic [8:0]  dx;
  logic [4:0]  rd_char;
  logic [5:0]  reveal_cnt;

  text_reveal_fsm #(
    .MAX_CHARS      (MAX_CHARS),
    .FRAMES_PER_CHAR(FRAMES_PER_CHAR)
  ) u_reveal (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .vsync_in  (vsync_in),
    .start     (start),
    .clear     (clear),
    .reveal_cnt(reveal_cnt),
    .done      (done)
  );

  always_comb begin
    // only the low bits of the offsets are ever consumed, so subtract narrow
    dx       = pix_x[8:0] - 9'(TEXT_X0);
    in_box_d = pix_valid
             && ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI)
             && ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
    col_d    = dx[8:4];
    lx_d     = dx[3:0];
    ly_d     = pix_y[3:0] - 4'(TEXT_Y0);
    rgb_d1_d = rgb_in;

    if ({1'b0, col_q} < SLOTS) begin
      rd_char = buf_q[col_q[AW-1:0]];
    end else begin
      rd_char = CHAR_BLANK;
    end
    letter_i_d = rd_char;
    letter_x_d = lx_q;
    letter_y_d = ly_q;
    show_d     = in_box_q && ({1'b0, col_q} < reveal_cnt);
    rgb_d2_d   = rgb_d1_q;

    rgb_out_d = (show_q && is_visible_code(letter_i_q) && letter_o) ? TEXT_COLOR : rgb_d2_q;
    hs_d      = {hs_q[1:0], hsync_in};
    vs_d      = {vs_q[1:0], vsync_in};

    buf_d = buf_q;
    if (wr_en && ({1'b0, wr_addr} < SLOTS)) begin
      buf_d[wr_addr[AW-1:0]] = wr_char;
    end else begin
      buf_d = buf_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      in_box_q   <= 1'b0;
      col_q      <= 5'd0;
      lx_q       <= 4'd0;
      ly_q       <= 4'd0;
      rgb_d1_q   <= RGB_BLACK;
      letter_i_q <= CHAR_A;
      letter_x_q <= 4'd0;
      letter_y_q <= 4'd0;
      show_q     <= 1'b0;
      rgb_d2_q   <= RGB_BLACK;
      rgb_out_q  <= RGB_BLACK;
      hs_q       <= 3'd0;
      vs_q       <= 3'd0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        buf_q[i] <= CHAR_BLANK;
      end
    end else begin
      in_box_q   <= in_box_d;
      col_q      <= col_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      rgb_d1_q   <= rgb_d1_d;
      letter_i_q <= letter_i_d;
      letter_x_q <= letter_x_d;
      letter_y_q <= letter_y_d;
      show_q     <= show_d;
      rgb_d2_q   <= rgb_d2_d;
      rgb_out_q  <= rgb_out_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      for (int i = 0; i < MAX_CHARS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign letter_i  = letter_i_q;
  assign letter_x  = letter_x_q;
  assign letter_y  = letter_y_q;
  assign rgb_out   = rgb_out_q;
  assign hsync_out = hs_q[2];
  assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: each driven pixel pushes its expected
// output, popped and compared when it leaves the three-stage pipeline.
module tb_text_overlay;

  localparam int          X0  = 192;
  localparam int          Y0  = 232;
  localparam int          NCH = 16;
  localparam logic [15:0] TC  = 16'hFFFF;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  pix_x = 10'd0, pix_y = 10'd0;
  logic        pix_valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [15:0] rgb_in = 16'd0;
  logic        wr_en = 1'b0, start = 1'b0, clear = 1'b0;
  logic [4:0]  wr_addr = 5'd0, wr_char = 5'd0;
  logic [4:0]  letter_i;
  logic [3:0]  letter_x, letter_y;
  logic        letter_o, hsync_out, vsync_out, done;
  logic [15:0] rgb_out;

  typedef struct {
    logic [15:0] rgb;
    logic        hs, vs;
    bit          chk, chk_l;
    logic [4:0]  li;
    logic [3:0]  lx, ly;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  bit         rst_req = 1'b1, vs_now = 1'b0, force_one = 1'b0;
  logic [4:0] m_buf [NCH];
  int         m_reveal = 0, m_state = 0;

  always #5 sys_clk = ~sys_clk;

  text_overlay #(
    .TEXT_X0(X0), .TEXT_Y0(Y0), .MAX_CHARS(NCH), .FRAMES_PER_CHAR(1), .TEXT_COLOR(TC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .start(start), .clear(clear),
    .letter_i(letter_i), .letter_x(letter_x), .letter_y(letter_y), .letter_o(letter_o),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out), .done(done)
  );

  // Stand-in glyph ROM: an arbitrary but fixed pattern.
  function automatic logic rom_bit(input logic [4:0] i, input logic [3:0] x, input logic [3:0] y);
    int s;
    s = int'(i) + int'(x) + int'(y);
    return (s % 3) == 0;
  endfunction

  assign letter_o = force_one | rom_bit(letter_i, letter_x, letter_y);

  always @(negedge sys_clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    exp_t e;
    int   li;
    @(negedge sys_clk);
    cyc++;
    if (q.size() >= 2) begin
      li = q.size() - 2;
      if (q[li].chk_l) begin
        checks++;
        if ({letter_i, letter_x, letter_y} !== {q[li].li, q[li].lx, q[li].ly}) begin
          errors++;
          $display("FAIL letter_addr: got i=%0d x=%0d y=%0d, want i=%0d x=%0d y=%0d",
                   letter_i, letter_x, letter_y, q[li].li, q[li].lx, q[li].ly);
        end
      end
    end
    if (q.size() >= 3) begin
      e = q.pop_front();
      checks++;
      if (hsync_out !== e.hs || vsync_out !== e.vs) begin
        errors++;
        $display("FAIL sync: got hs=%b vs=%b, want hs=%b vs=%b", hsync_out, vsync_out, e.hs, e.vs);
      end
      if (e.chk) begin
        checks++;
        if (rgb_out !== e.rgb) begin
          errors++;
          $display("FAIL rgb: got %h, want %h (cycle %0d)", rgb_out, e.rgb, cyc);
        end
      end
    end
  endtask

  task automatic px(input int x, input int y, input logic v, input logic [15:0] bg,
                    input bit chk, input bit chk_l);
    exp_t e;
    int   col;
    bit   inb;
    step();
    sys_rst   = rst_req;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = v;
    rgb_in    = bg;
    hsync_in  = cyc[1];
    vsync_in  = vs_now;
    if (rst_req) begin
      for (int i = 0; i < NCH; i++) m_buf[i] = 5'd31;
      m_reveal = 0;
      m_state  = 0;
      foreach (q[i]) begin
        q[i].rgb = 16'd0; q[i].hs = 1'b0; q[i].vs = 1'b0; q[i].chk_l = 1'b0;
      end
    end
    inb   = v && x >= X0 && x < X0 + 16 * NCH && y >= Y0 && y < Y0 + 16;
    col   = inb ? (x - X0) / 16 : 0;
    e.li  = m_buf[col];
    e.lx  = 4'(x - X0);
    e.ly  = 4'(y - Y0);
    e.rgb = (inb && col < m_reveal && m_buf[col] < 5'd26 &&
             (force_one || rom_bit(m_buf[col], e.lx, e.ly))) ? TC : bg;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.chk = chk;
    e.chk_l = chk_l;
    if (rst_req) begin
      e.rgb = 16'd0; e.hs = 1'b0; e.vs = 1'b0; e.chk_l = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic idle();
    px(0, 0, 1'b0, 16'h0F0F, 1'b1, 1'b0);
  endtask

  task automatic scan(input int slot, input int row, input bit chk_l);
    for (int lx = 0; lx < 16; lx++)
      px(X0 + slot * 16 + lx, Y0 + row, 1'b1, 16'(16'h2100 + slot * 16 + lx), 1'b1, chk_l);
  endtask

  task automatic wr(input int addr, input int code);
    repeat (3) idle();
    wr_en = 1'b1; wr_addr = 5'(addr); wr_char = 5'(code);
    idle();
    wr_en = 1'b0;
    if (addr < NCH) m_buf[addr] = 5'(code);
  endtask

  task automatic pulse_start();
    repeat (3) idle();
    start = 1'b1;
    idle();
    start = 1'b0;
    m_state = 1; m_reveal = 0;
  endtask

  task automatic vsync_pulse();
    vs_now = 1'b1;
    repeat (2) idle();
    vs_now = 1'b0;
    repeat (4) idle();
    if (m_state == 1) begin
      m_reveal++;
      if (m_reveal == NCH) m_state = 2;
    end
  endtask

  task automatic set_force(input bit f);
    repeat (3) idle();
    force_one = f;
    idle();
  endtask

  task automatic check_done(input string name, input int want);
    checks++;
    if (done_cnt !== want) begin
      errors++;
      $display("FAIL %s: done pulses got %0d, want %0d", name, done_cnt, want);
    end
  endtask

  task automatic check_zero_ctl(input string name);
    checks++;
    if ({letter_i, letter_x, letter_y, done} !== 14'd0) begin
      errors++;
      $display("FAIL %s: got i=%0d x=%0d y=%0d done=%b, want all 0",
               name, letter_i, letter_x, letter_y, done);
    end
  endtask

  task automatic test_reset();
    repeat (4) idle();
    check_zero_ctl("reset_outputs");
    rst_req = 1'b0;
    repeat (3) idle();
    scan(0, 0, 1'b1);
    px(X0 - 20, Y0, 1'b1, 16'h1357, 1'b1, 1'b0);
    repeat (3) idle();
    check_done("reset_no_done", 0);
  endtask

  task automatic test_reveal_hi();
    wr(0, 7);
    wr(1, 8);
    wr(16, 0);
    pulse_start();
    vsync_pulse();
    scan(0, 5, 1'b1);
    scan(1, 5, 1'b1);
    vsync_pulse();
    scan(1, 5, 1'b0);
    scan(2, 5, 1'b0);
    repeat (13) vsync_pulse();
    check_done("done_before_last", 0);
    vsync_pulse();
    check_done("done_after_last", 1);
    vsync_pulse();
    check_done("done_held", 1);
  endtask

  task automatic test_rom_addr();
    wr(0, 0);
    px(X0 + 3, Y0 + 5, 1'b1, 16'h4444, 1'b1, 1'b1);
    px(X0 + 4, Y0 + 5, 1'b1, 16'h5555, 1'b1, 1'b1);
    repeat (3) idle();
  endtask

  task automatic test_boundaries();
    wr(15, 0);
    set_force(1'b1);
    px(X0 - 1,   Y0 + 4,  1'b1, 16'h0101, 1'b1, 1'b0);
    px(X0 + 256, Y0 + 4,  1'b1, 16'h0202, 1'b1, 1'b0);
    px(X0 + 5,   Y0 + 16, 1'b1, 16'h0303, 1'b1, 1'b0);
    px(X0 + 5,   Y0 - 1,  1'b1, 16'h0404, 1'b1, 1'b0);
    px(X0 + 5,   Y0 + 4,  1'b0, 16'h0505, 1'b1, 1'b0);
    px(X0,       Y0,      1'b1, 16'h0606, 1'b1, 1'b1);
    px(X0 + 255, Y0 + 15, 1'b1, 16'h0707, 1'b1, 1'b1);
    repeat (3) idle();
  endtask

  task automatic test_blank_code();
    wr(2, 27);
    scan(2, 3, 1'b1);
    scan(1, 3, 1'b0);
  endtask

  task automatic test_clear_start();
    int d0;
    pulse_start();
    vsync_pulse();
    scan(0, 1, 1'b0);
    repeat (3) idle();
    clear = 1'b1; start = 1'b1;
    idle();
    clear = 1'b0; start = 1'b0;
    m_state = 0; m_reveal = 0;
    scan(0, 1, 1'b0);
    d0 = done_cnt;
    repeat (17) vsync_pulse();
    scan(0, 2, 1'b0);
    check_done("clear_no_done", d0);
  endtask

  task automatic test_reset_mid();
    int d0;
    pulse_start();
    vsync_pulse();
    vsync_pulse();
    scan(1, 6, 1'b0);
    d0 = done_cnt;
    rst_req = 1'b1;
    idle();
    idle();
    check_zero_ctl("mid_reset_outputs");
    idle();
    rst_req = 1'b0;
    repeat (3) idle();
    scan(0, 2, 1'b1);
    scan(1, 2, 1'b1);
    repeat (17) vsync_pulse();
    check_done("mid_reset_no_done", d0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) m_buf[i] = 5'd31;
    test_reset();
    test_reveal_hi();
    test_rom_addr();
    test_boundaries();
    test_blank_code();
    set_force(1'b0);
    set_force(1'b1);
    test_clear_start();
    test_reset_mid();
    repeat (4) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Upstream driver and downstream mixer for the `letter` glyph ROM, with a typewriter reveal.
- Takes VGA scan coordinates from the VGA timing stage and decides whether the pixel is inside a one-line text box.
- If it is, it computes the character index and the pixel position within the glyph and drives the `letter` ROM. It then mixes the returned glyph bit into the RGB stream.
- A small string buffer holds the message; a frame-based reveal FSM "types" it one character at a time.

Parameters:
- TEXT_X0, 192: left pixel column of the text box.
- TEXT_Y0, 232: top pixel row of the text box.
- MAX_CHARS, 16: character slots in the line; box width is MAX_CHARS*16 pixels, height 16.
- FRAMES_PER_CHAR, 8: frames between successive character reveals (must be 1 or more).
- TEXT_COLOR, 16'hFFFF: RGB565 colour drawn where the glyph bit is 1.

Ports:
- sys_clk  in  1  pixel clock.
- sys_rst  in  1  synchronous, active-high reset.
- pix_x  in  10  current scan column.
- pix_y  in  10  current scan row.
- pix_valid  in  1  active-video flag.
- hsync_in  in  1  horizontal sync, aligned with pix_x.
- vsync_in  in  1  vertical sync, aligned with pix_x.
- rgb_in  in  16  background pixel, aligned with pix_x.
- wr_en  in  1  string buffer write strobe.
- wr_addr  in  5  slot index, 0..MAX_CHARS-1.
- wr_char  in  5  letter code: 0..25 = A..Z, 26..31 = blank.
- start  in  1  one-cycle pulse that begins or restarts the reveal.
- clear  in  1  one-cycle pulse that hides the text and returns to IDLE.
- letter_i  out  5  to the ROM: letter index.
- letter_x  out  4  to the ROM: glyph column.
- letter_y  out  4  to the ROM: glyph row.
- letter_o  in  1  from the ROM: combinational glyph bit.
- hsync_out  out  1  hsync_in delayed 3 cycles.
- vsync_out  out  1  vsync_in delayed 3 cycles.
- rgb_out  out  16  mixed pixel.
- done  out  1  one-cycle pulse when the last character is revealed.

Behaviour:
- Reset (synchronous, sys_rst=1 at a clock edge):
  - All pipeline registers, rgb_out, hsync_out, vsync_out, done and letter_* go to 0.
  - FSM goes to IDLE; reveal_cnt=0, frame_cnt=0.
  - Every buffer slot is set to 31 (blank).
  - Reset mid-reveal aborts the reveal with no done pulse.
- Pipeline, stage 1 (registered):
  - in_box = pix_valid, with TEXT_X0 <= pix_x < TEXT_X0+16*MAX_CHARS and TEXT_Y0 <= pix_y < TEXT_Y0+16.
  - dx = pix_x-TEXT_X0; col = dx[8:4]; lx = dx[3:0]; ly = (pix_y-TEXT_Y0)[3:0].
  - Subtractions are 10-bit; results are used only when in_box=1.
- Pipeline, stage 2 (registered):
  - letter_i <= buffer[col] (synchronous, read-first); letter_x <= lx; letter_y <= ly.
  - show <= in_box & (col < reveal_cnt).
- Pipeline, stage 3 (registered):
  - rgb_out <= (show & (letter_i < 26) & letter_o) ? TEXT_COLOR : rgb_d2.
  - Codes 26..31 never index the ROM's visible output; they render background.
- Latency: exactly 3 cycles on rgb, hsync and vsync; the sync signals are delayed by matching shift registers.
- Buffer writes:
  - Take effect at the clock edge; a write to an address read in the same cycle returns the old value.
  - wr_addr >= MAX_CHARS is ignored.
- Frame tick: one-cycle pulse on the registered rising edge of vsync_in.
- FSM:
  - IDLE: reveal_cnt=0. start moves to TYPE with frame_cnt=0, reveal_cnt=0.
  - TYPE: on each frame tick, if frame_cnt==FRAMES_PER_CHAR-1 then frame_cnt=0 and reveal_cnt++; otherwise frame_cnt++. When reveal_cnt becomes MAX_CHARS, go to DONE and pulse done for one cycle.
  - DONE: reveal_cnt holds MAX_CHARS.
  - clear in any state moves to IDLE next cycle; clear takes priority over a simultaneous start.
  - start in TYPE or DONE restarts from reveal_cnt=0.
  - A frame tick in the same cycle as start is ignored.
- reveal_cnt updates take effect between pixels; a character may appear mid-frame, and that is allowed.

Decomposition:
- Shared package:
  - RGB565 colour constants.
  - Letter-code constants (CHAR_A=0, CHAR_BLANK=31, NUM_GLYPHS=26).
  - Glyph size constant GLYPH_W=16.
  - FSM state encoding (IDLE, TYPE, DONE).
- One natural sub-module: text_reveal_fsm, containing the frame tick detector, frame_cnt, reveal_cnt and done. The pipeline and buffer stay in the top level.

Test Plan:
- Write "HI" (slot0=7, slot1=8) and blanks elsewhere, start, FRAMES_PER_CHAR=1 -> after 1 vsync edge only slot0 pixels show TEXT_COLOR; after 2 edges slot1 also shows; done pulses exactly once after the 16th edge.
- Pixel (TEXT_X0+3, TEXT_Y0+5) in DONE with slot0=0 -> letter_i=0, letter_x=3, letter_y=5 two cycles later; rgb_out equals TEXT_COLOR iff letter_o=1, three cycles after input.
- Pixels at x=TEXT_X0-1, x=TEXT_X0+256, y=TEXT_Y0+16, and pix_valid=0 -> rgb_out equals rgb_in delayed 3 cycles.
- Slot code 27 in DONE with letter_o forced 1 -> background passes through.
- Assert clear and start in the same cycle during TYPE -> IDLE; no text drawn; no done pulse.
- Assert sys_rst mid-TYPE -> all outputs 0 next cycle; buffer reads return 31; hsync_out/vsync_out resume with 3-cycle delay.
